// File: rtl/mips_pkg.sv
// Shared opcode encodings, controller state and PC-source types for the multi-cycle MIPS control path.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic is_r;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic legal;
  } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: one-hot instruction class plus a legal flag.
module opcode_class
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  // Match the opcode against the supported instruction set.
  always_comb begin
    cls         = '0;
    cls.is_r    = (opcode == OP_RTYPE);
    cls.is_addi = (opcode == OP_ADDI);
    cls.is_lw   = (opcode == OP_LW);
    cls.is_sw   = (opcode == OP_SW);
    cls.is_beq  = (opcode == OP_BEQ);
    cls.is_j    = (opcode == OP_J);
    cls.legal   = cls.is_r | cls.is_addi | cls.is_lw | cls.is_sw | cls.is_beq | cls.is_j;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with memory wait timeout and sticky traps.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memread,
  output logic       memwrite,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pcsrc,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

  ctrl_state_t      state, nxt;
  logic [5:0]       op_q;
  logic [5:0]       op_sel;
  op_class_t        cls;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             tmo;
  logic             ill_q, bus_q;
  logic             set_ill, set_bus;

  // Raw strobes before reset gating
  logic   mem_req_c, memread_c, memwrite_c, ir_write_c, pc_write_c;
  logic   regdest_c, regwrite_c, alusrc_c, memtoreg_c, done_c;
  pcsrc_t pc_sel;

  // DECODE classifies the live IR; afterwards the latched copy drives the instruction.
  assign op_sel = (state == S_DECODE) ? opcode : op_q;

  opcode_class u_cls (
    .opcode (op_sel),
    .cls    (cls)
  );

  // This wait cycle is the last one allowed; a ready in it still wins.
  assign cnt_inc = cnt + 1'b1;
  assign tmo     = (cnt_inc == TMO_VAL);

  // Next-state and strobe decode from current state (zero only matters in EXEC for beq).
  always_comb begin
    nxt        = state;
    mem_req_c  = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    ir_write_c = 1'b0;
    pc_write_c = 1'b0;
    pc_sel     = PC_PLUS4;
    regdest_c  = 1'b0;
    regwrite_c = 1'b0;
    alusrc_c   = 1'b0;
    memtoreg_c = 1'b0;
    done_c     = 1'b0;
    set_ill    = 1'b0;
    set_bus    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        memread_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          nxt        = S_DECODE;
        end else if (tmo) begin
          set_bus = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_DECODE: begin
        if (cls.legal) nxt = S_EXEC;
        else begin
          set_ill = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_EXEC: begin
        alusrc_c = cls.is_addi | cls.is_lw | cls.is_sw;
        if (cls.is_r || cls.is_addi) nxt = S_WB;
        else if (cls.is_lw || cls.is_sw) nxt = S_MEM;
        else if (cls.is_beq) begin
          pc_sel     = PC_BRANCH;
          pc_write_c = zero;
          done_c     = 1'b1;
          nxt        = S_FETCH;
        end else begin
          pc_sel     = PC_JUMP;
          pc_write_c = 1'b1;
          done_c     = 1'b1;
          nxt        = S_FETCH;
        end
      end
      S_MEM: begin
        alusrc_c   = 1'b1;
        mem_req_c  = 1'b1;
        memread_c  = cls.is_lw;
        memwrite_c = cls.is_sw;
        if (mem_ready) begin
          if (cls.is_lw) nxt = S_WB;
          else begin
            done_c = 1'b1;
            nxt    = S_FETCH;
          end
        end else if (tmo) begin
          set_bus = 1'b1;
          nxt     = S_TRAP;
        end
      end
      S_WB: begin
        regwrite_c = 1'b1;
        regdest_c  = cls.is_r;
        memtoreg_c = cls.is_lw;
        alusrc_c   = cls.is_addi | cls.is_lw;
        done_c     = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nxt;
  end

  // Capture the opcode once, at DECODE.
  always_ff @(posedge clk) begin
    if (!rst_n)                 op_q <= '0;
    else if (state == S_DECODE) op_q <= opcode;
  end

  // Wait counter: restarts on every state change, counts stalled request cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || (nxt != state)) cnt <= '0;
    else if (mem_req_c)           cnt <= cnt_inc;
  end

  // Sticky trap causes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
      bus_q <= 1'b0;
    end else begin
      if (set_ill) ill_q <= 1'b1;
      if (set_bus) bus_q <= 1'b1;
    end
  end

  // Everything is forced low while reset is held, including stale flags.
  assign mem_req    = rst_n ? mem_req_c  : 1'b0;
  assign memread    = rst_n ? memread_c  : 1'b0;
  assign memwrite   = rst_n ? memwrite_c : 1'b0;
  assign ir_write   = rst_n ? ir_write_c : 1'b0;
  assign pc_write   = rst_n ? pc_write_c : 1'b0;
  assign pcsrc      = rst_n ? pc_sel     : 2'b00;
  assign regdest    = rst_n ? regdest_c  : 1'b0;
  assign regwrite   = rst_n ? regwrite_c : 1'b0;
  assign alusrc     = rst_n ? alusrc_c   : 1'b0;
  assign memtoreg   = rst_n ? memtoreg_c : 1'b0;
  assign instr_done = rst_n ? done_c     : 1'b0;
  assign illegal_op = rst_n ? ill_q      : 1'b0;
  assign bus_err    = rst_n ? bus_q      : 1'b0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: scoreboard of expected retirements plus trap/reset checks.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memread, memwrite, ir_write, pc_write;
  logic [1:0] pcsrc;
  logic       regdest, regwrite, alusrc, memtoreg, instr_done, illegal_op, bus_err;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         lat;
    logic       pw;
    logic [1:0] ps;
    logic       rw, rd, m2r, als, mw;
    int         nrd;
  } exp_t;

  exp_t sbq[$];

  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memread(memread), .memwrite(memwrite), .ir_write(ir_write),
    .pc_write(pc_write), .pcsrc(pcsrc), .regdest(regdest), .regwrite(regwrite),
    .alusrc(alusrc), .memtoreg(memtoreg), .instr_done(instr_done),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [13:0] outs();
    return {mem_req, memread, memwrite, ir_write, pc_write, pcsrc, regdest,
            regwrite, alusrc, memtoreg, instr_done, illegal_op, bus_err};
  endfunction

  // Hold reset 3 cycles with mem_ready high; leaves us in cycle 1 of FETCH.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0; zero = 1'b0;
    repeat (3) begin
      #1 chk("reset_outs", outs(), 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1 chk("mem_req_after_reset", mem_req, 1);
  endtask

  // Run one instruction; mem_ready drops for mdly cycles from cycle 4 (MEM).
  task automatic run_instr(input string nm, input logic [5:0] op, input logic z,
                           input int mdly, input logic swap, input exp_t e);
    exp_t g;
    int   nrd = 0;
    bit   done = 0;
    sbq.push_back(e);
    for (int c = 1; c <= 20 && !done; c++) begin
      opcode    = (swap && c > 2) ? OP_J : op;
      zero      = z;
      mem_ready = !(c >= 4 && c < 4 + mdly);
      #1;
      if (c == 1) chk({nm, "_done_c1"}, instr_done, 0);
      if (memread) nrd++;
      if (instr_done) begin
        done = 1;
        if (sbq.size() == 0) chk({nm, "_sb_empty"}, 1, 0);
        else begin
          g = sbq.pop_front();
          chk({nm, "_latency"},  c,        g.lat);
          chk({nm, "_pc_write"}, pc_write, g.pw);
          chk({nm, "_pcsrc"},    pcsrc,    g.ps);
          chk({nm, "_regwrite"}, regwrite, g.rw);
          chk({nm, "_regdest"},  regdest,  g.rd);
          chk({nm, "_memtoreg"}, memtoreg, g.m2r);
          chk({nm, "_alusrc"},   alusrc,   g.als);
          chk({nm, "_memwrite"}, memwrite, g.mw);
          chk({nm, "_memread_n"}, nrd,     g.nrd);
          chk({nm, "_flags"}, {illegal_op, bus_err}, 0);
        end
      end
      @(posedge clk); #1;
    end
    if (!done) chk({nm, "_retire"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    //                                 lat pw ps rw rd m2r als mw nrd
    run_instr("addi", OP_ADDI,  0, 0, 0, '{4, 0, 0, 1, 0, 0, 1, 0, 1});
    run_instr("rtyp", OP_RTYPE, 0, 0, 0, '{4, 0, 0, 1, 1, 0, 0, 0, 1});
    run_instr("lw",   OP_LW,    0, 3, 1, '{8, 0, 0, 1, 0, 1, 1, 0, 5});
    run_instr("sw",   OP_SW,    0, 0, 0, '{4, 0, 0, 0, 0, 0, 1, 1, 1});
    run_instr("beq0", OP_BEQ,   0, 0, 0, '{3, 0, 1, 0, 0, 0, 0, 0, 1});
    run_instr("beq1", OP_BEQ,   1, 0, 0, '{3, 1, 1, 0, 0, 0, 0, 0, 1});
    run_instr("j",    OP_J,     0, 0, 0, '{3, 1, 2, 0, 0, 0, 0, 0, 1});
    chk("sb_drained", sbq.size(), 0);

    // Reset in the middle of a stalled sw: no retire, request gone, back to FETCH.
    opcode = OP_SW; zero = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      mem_ready = 1'b1; #1; @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1 chk("sw_mem_req", {mem_req, memwrite}, 2'b11);
    rst_n = 1'b0;
    #1 chk("sw_abort_outs", outs(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("sw_abort_fetch", {mem_req, memread, memwrite, instr_done}, 4'b1100);

    // Illegal opcode traps and stays put.
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (c == 2) chk("ill_decode", illegal_op, 0);
      if (c >= 3) chk("ill_trap", outs(), 14'b10);
      @(posedge clk); #1;
    end

    // No mem_ready ever: four wait cycles, bus error in cycle 5.
    do_reset();
    opcode = OP_ADDI; mem_ready = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      if (c <= 4) chk("tmo_wait", {mem_req, bus_err}, 2'b10);
      else        chk("tmo_trap", outs(), 14'b1);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
